mac_array_pp: RTL and testbench

Parametrised successor of the 32-lane MAC array for the RepVGG accelerator. It computes per-pixel dot products over `LANES` input channels and 9 (3x3) or 1 (1x1) kernel taps. Weights are double-buffered in ping-pong banks so the next output channel can load during compute. Results reach the psum accumulator through an output FIFO with a valid/ready handshake, and the imap request stream stalls on backpressure.

---
 rtl/mac_array_pp_if.sv | 26 ++
 rtl/mac_array_pp.sv | 195 +++++++++++++++++++
 tb/tb_mac_array_pp.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_pp_if.sv
// Streaming ports of mac_array_pp: imap read request/response and the result FIFO head.
// imap: imap_rdata is valid exactly one cycle after imap_ren; out: a beat transfers on the
// rising edge where out_vld && out_rdy, and out_data/out_info hold steady while out_vld && !out_rdy.
interface mac_array_pp_if #(
    parameter int LANES = 32,
    parameter int DW    = 8,
    parameter int ACC_W = 32
);
    logic                  imap_ren;
    logic [31:0]           imap_raddr;
    logic [LANES*DW-1:0]   imap_rdata;
    logic [ACC_W-1:0]      out_data;
    logic [31:0]           out_info;
    logic                  out_vld;
    logic                  out_rdy;

    modport master (
        output imap_ren, imap_raddr, out_data, out_info, out_vld,
        input  imap_rdata, out_rdy
    );

    modport slave (
        input  imap_ren, imap_raddr, out_data, out_info, out_vld,
        output imap_rdata, out_rdy
    );
endinterface

// File: rtl/mac_array_pp.sv
// Ping-pong weighted MAC array: per-pixel dot products over LANES channels and 1 or 9 taps,
// with results leaving through a credit-protected output FIFO.
module mac_array_pp #(
    parameter int LANES       = 32,
    parameter int DW          = 8,
    parameter int ACC_W       = 32,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                conv_start,
    input  logic                conv_mode,
    input  logic [15:0]         map_size,
    input  logic [7:0]          out_ch,
    output logic                busy,
    output logic                conv_done,
    output logic [7:0]          out_ch_cnt,
    input  logic                weight_wen,
    input  logic [4:0]          weight_waddr,
    input  logic [LANES*DW-1:0] weight_wdata,
    input  logic                weight_commit,
    input  logic                weight_commit_bank,
    output logic [1:0]          weight_bank_vld,
    output logic [2:0]          dbg_state,
    mac_array_pp_if.master      bus
);
    localparam int VW    = LANES * DW;
    localparam int PW    = 2 * DW;
    localparam int PTR_W = $clog2(OFIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_W, S_RUN, S_DRAIN, S_NEXT, S_FLUSH, S_DONE} state_t;
    state_t state_q, state_d;

    logic           mode_q;
    logic [15:0]    size_q, pix_q;
    logic [7:0]     och_total_q, och_q;
    logic [3:0]     tap_q;
    logic [31:0]    addr_q;
    logic [PTR_W:0] inflight_q, wr_q, rd_q, fifo_cnt;
    logic [1:0]     bank_vld_q, bank_vld_d;
    logic [VW-1:0]  wbank [2][9];

    logic last_tap, last_pix, credit_ok, issue, first_issue, push, pop;

    // Three-stage datapath: weight fetch, lane products, adder tree; accumulate on stage 3.
    logic                    v1_q, v2_q, v3_q;
    logic                    first1_q, first2_q, first3_q, last1_q, last2_q, last3_q;
    logic [15:0]             pix1_q, pix2_q, pix3_q;
    logic [7:0]              och1_q, och2_q, och3_q;
    logic [VW-1:0]           w1_q;
    logic signed [PW-1:0]    prod_d [LANES];
    logic signed [PW-1:0]    prod_q [LANES];
    logic signed [ACC_W-1:0] tree_sum, sum_q, acc_q, acc_d;

    logic [ACC_W-1:0] fifo_data [OFIFO_DEPTH];
    logic [31:0]      fifo_info [OFIFO_DEPTH];

    assign fifo_cnt    = wr_q - rd_q;
    assign last_tap    = mode_q ? 1'b1 : (tap_q == 4'd8);
    assign last_pix    = (pix_q == size_q - 16'd1);
    assign credit_ok   = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < (PTR_W + 2)'(OFIFO_DEPTH);
    // Only the first tap of a pixel needs a credit; the rest follow back-to-back.
    assign issue       = (state_q == S_RUN) && ((tap_q != 4'd0) || credit_ok);
    assign first_issue = issue && (tap_q == 4'd0);
    assign push        = v3_q && last3_q;
    assign pop         = bus.out_vld && bus.out_rdy;
    assign acc_d       = first3_q ? sum_q : acc_q + sum_q;

    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign conv_done       = (state_q == S_DONE);
    assign out_ch_cnt      = och_q;
    assign weight_bank_vld = bank_vld_q;
    assign dbg_state       = state_q;

    assign bus.imap_ren   = issue;
    assign bus.imap_raddr = addr_q + {28'd0, tap_q};
    assign bus.out_vld    = (wr_q != rd_q);
    assign bus.out_data   = bus.out_vld ? fifo_data[rd_q[PTR_W-1:0]] : '0;
    assign bus.out_info   = bus.out_vld ? fifo_info[rd_q[PTR_W-1:0]] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (conv_start) state_d = (out_ch == 8'd0 || map_size == 16'd0) ? S_DONE : S_WAIT_W;
            S_WAIT_W: if (bank_vld_q[och_q[0]]) state_d = S_RUN;
            S_RUN:    if (issue && last_tap && last_pix) state_d = S_DRAIN;
            S_DRAIN:  if (inflight_q == '0) state_d = S_NEXT;
            S_NEXT:   state_d = (och_q + 8'd1 == och_total_q) ? S_FLUSH : S_WAIT_W;
            S_FLUSH:  if (fifo_cnt == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A commit landing in the same cycle as the release of that bank keeps it valid.
    always_comb begin
        bank_vld_d = bank_vld_q;
        if (state_q == S_NEXT) bank_vld_d[och_q[0]] = 1'b0;
        if (weight_commit) bank_vld_d[weight_commit_bank] = 1'b1;
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            prod_d[l] = PW'($signed(bus.imap_rdata[l*DW +: DW])) * PW'($signed(w1_q[l*DW +: DW]));
        tree_sum = '0;
        for (int l = 0; l < LANES; l++)
            tree_sum = tree_sum + ACC_W'(prod_q[l]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bank_vld_q  <= 2'b00;
            mode_q      <= 1'b0;
            size_q      <= 16'd0;
            och_total_q <= 8'd0;
            och_q       <= 8'd0;
            tap_q       <= 4'd0;
            pix_q       <= 16'd0;
            addr_q      <= 32'd0;
            inflight_q  <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_vld_q <= bank_vld_d;
            v1_q       <= issue;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            if (state_q == S_IDLE && conv_start) begin
                mode_q      <= conv_mode;
                size_q      <= map_size;
                och_total_q <= out_ch;
                och_q       <= 8'd0;
                tap_q       <= 4'd0;
                pix_q       <= 16'd0;
                addr_q      <= 32'd0;
            end
            if (issue) begin
                if (last_tap) begin
                    tap_q  <= 4'd0;
                    pix_q  <= pix_q + 16'd1;
                    addr_q <= addr_q + (mode_q ? 32'd1 : 32'd9);
                end else begin
                    tap_q <= tap_q + 4'd1;
                end
            end
            if (state_q == S_NEXT) begin
                och_q  <= och_q + 8'd1;
                tap_q  <= 4'd0;
                pix_q  <= 16'd0;
                addr_q <= 32'd0;
            end
            case ({first_issue, push})
                2'b10:   inflight_q <= inflight_q + CNT_ONE;
                2'b01:   inflight_q <= inflight_q - CNT_ONE;
                default: ;
            endcase
            if (push) wr_q <= wr_q + CNT_ONE;
            if (pop)  rd_q <= rd_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (weight_wen && weight_waddr[3:0] < 4'd9 && !bank_vld_q[weight_waddr[4]])
            wbank[weight_waddr[4]][weight_waddr[3:0]] <= weight_wdata;
        w1_q     <= wbank[och_q[0]][tap_q];
        first1_q <= (tap_q == 4'd0);
        last1_q  <= last_tap;
        pix1_q   <= pix_q;
        och1_q   <= och_q;
        prod_q   <= prod_d;
        first2_q <= first1_q;
        last2_q  <= last1_q;
        pix2_q   <= pix1_q;
        och2_q   <= och1_q;
        sum_q    <= tree_sum;
        first3_q <= first2_q;
        last3_q  <= last2_q;
        pix3_q   <= pix2_q;
        och3_q   <= och2_q;
        if (v3_q) acc_q <= acc_d;
        if (push) begin
            fifo_data[wr_q[PTR_W-1:0]] <= acc_d;
            fifo_info[wr_q[PTR_W-1:0]] <= {8'd0, och3_q, pix3_q};
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_cnt == (PTR_W + 1)'(OFIFO_DEPTH)));
endmodule

// File: tb/tb_mac_array_pp.sv
// Randomized bench for mac_array_pp: a tap-level dot-product model fills the result and
// address queues, and a negedge monitor pops and compares against DUT traffic.
module tb_mac_array_pp;
    localparam int LANES = 32;
    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int DEPTH = 4;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          conv_start, conv_mode;
    logic [15:0]   map_size;
    logic [7:0]    out_ch;
    logic          busy, conv_done;
    logic [7:0]    out_ch_cnt;
    logic          weight_wen;
    logic [4:0]    weight_waddr;
    logic [VW-1:0] weight_wdata;
    logic          weight_commit, weight_commit_bank;
    logic [1:0]    weight_bank_vld;
    logic [2:0]    dbg_state;

    mac_array_pp_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) bus ();

    mac_array_pp #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .OFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .conv_start(conv_start), .conv_mode(conv_mode),
        .map_size(map_size), .out_ch(out_ch), .busy(busy), .conv_done(conv_done),
        .out_ch_cnt(out_ch_cnt), .weight_wen(weight_wen), .weight_waddr(weight_waddr),
        .weight_wdata(weight_wdata), .weight_commit(weight_commit),
        .weight_commit_bank(weight_commit_bank), .weight_bank_vld(weight_bank_vld),
        .dbg_state(dbg_state), .bus(bus)
    );

    // ---------------- clock / memory model / ready driver ----------------
    always #5 clk = ~clk;

    logic [VW-1:0] imap_mem [256];
    int rdy_mode = 1;

    always @(posedge clk) bus.imap_rdata <= bus.imap_ren ? imap_mem[bus.imap_raddr[7:0]] : '0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_rdy = 1'b0;
            1:       bus.out_rdy = 1'b1;
            default: bus.out_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [ACC_W+31:0] exp_q[$];
    logic [31:0]       addr_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    int i_pat = 0;
    int w_pat = 0;
    logic cur_mode = 1'b0;
    int cur_size = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imap_ren) begin
                ren_cnt++;
                if (addr_q.size() == 0) check("ren_unexpected", bus.imap_ren, 1'b0);
                else check("imap_raddr", bus.imap_raddr, addr_q.pop_front());
            end
            if (bus.out_vld && bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", bus.out_vld, 1'b0);
                end else begin
                    logic [ACC_W+31:0] e;
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e[ACC_W-1:0]);
                    check("out_info", bus.out_info, e[ACC_W+31:ACC_W]);
                end
            end
            if (conv_done) done_cnt++;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [DW-1:0] pat_byte(input int p);
        if (p == 1) return DW'(1);
        if (p == 2) return {1'b1, {(DW-1){1'b0}}};
        return DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    task automatic fill_imap();
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < LANES; l++) imap_mem[a][l*DW +: DW] = pat_byte(i_pat);
    endtask

    // ---------------- driver tasks (entered and left at posedge + 1) ----------------
    task automatic wr_w(input logic b, input logic [3:0] t, input logic [VW-1:0] d);
        weight_wen = 1'b1;
        weight_waddr = {b, t};
        weight_wdata = d;
        @(posedge clk); #1;
        weight_wen = 1'b0;
    endtask

    // Loads channel o into bank o%2, then queues its expected addresses and results.
    task automatic load_ch(input int o);
        logic [VW-1:0] w [9];
        int k;
        longint acc;
        k = cur_mode ? 1 : 9;
        for (int t = 0; t < 9; t++) begin
            for (int l = 0; l < LANES; l++) w[t][l*DW +: DW] = pat_byte(w_pat);
            wr_w(1'(o % 2), 4'(t), w[t]);
        end
        weight_commit = 1'b1;
        weight_commit_bank = 1'(o % 2);
        @(posedge clk); #1;
        weight_commit = 1'b0;
        for (int p = 0; p < cur_size; p++) begin
            acc = 0;
            for (int t = 0; t < k; t++) begin
                addr_q.push_back(32'(p * k + t));
                for (int l = 0; l < LANES; l++)
                    acc += longint'($signed(imap_mem[p*k+t][l*DW +: DW])) *
                           longint'($signed(w[t][l*DW +: DW]));
            end
            exp_q.push_back({8'd0, 8'(o), 16'(p), ACC_W'(acc)});
        end
    endtask

    task automatic auto_load(input int nch);
        int nxt = 0;
        int guard = 0;
        while (nxt < nch && guard < 20000) begin
            if (!weight_bank_vld[nxt % 2]) begin
                load_ch(nxt);
                nxt++;
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
    endtask

    task automatic start(input int nch);
        conv_mode = cur_mode;
        map_size = 16'(cur_size);
        out_ch = 8'(nch);
        conv_start = 1'b1;
        @(posedge clk); #1;
        conv_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!conv_done && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_seen", conv_done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_conv_done"}, conv_done, 1'b0);
        check({tag, "_out_ch_cnt"}, out_ch_cnt, 8'd0);
        check({tag, "_imap_ren"}, bus.imap_ren, 1'b0);
        check({tag, "_imap_raddr"}, bus.imap_raddr, 32'd0);
        check({tag, "_out_vld"}, bus.out_vld, 1'b0);
        check({tag, "_out_data"}, bus.out_data, '0);
        check({tag, "_out_info"}, bus.out_info, 32'd0);
        check({tag, "_bank_vld"}, weight_bank_vld, 2'b00);
        check({tag, "_state"}, dbg_state, 3'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_addr_left"}, 64'(addr_q.size()), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int r0, d0, c;
        conv_start = 1'b0; conv_mode = 1'b0; map_size = '0; out_ch = '0;
        weight_wen = 1'b0; weight_waddr = '0; weight_wdata = '0;
        weight_commit = 1'b0; weight_commit_bank = 1'b0;
        #3;
        do_reset("reset");

        // 3x3 basic: all ones -> 288 per pixel, addresses 0..17
        i_pat = 1; w_pat = 1; fill_imap();
        cur_mode = 1'b0; cur_size = 2; rdy_mode = 1;
        load_ch(0);
        r0 = ren_cnt; d0 = done_cnt;
        start(1);
        check("latency_c1_ren", bus.imap_ren, 1'b0);
        check("latency_busy", busy, 1'b1);
        @(posedge clk); #1;
        check("latency_c2_ren", bus.imap_ren, 1'b1);
        wait_done(500);
        check("basic_reads", 64'(ren_cnt - r0), 64'd18);
        check("basic_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("basic_bank_vld", weight_bank_vld, 2'b00);
        check_drained("basic");

        // 1x1 signed corner: (-128)*(-128) over 32 lanes
        i_pat = 2; w_pat = 2; fill_imap();
        cur_mode = 1'b1; cur_size = 3;
        load_ch(0);
        r0 = ren_cnt;
        start(1);
        wait_done(300);
        check("signed_reads", 64'(ren_cnt - r0), 64'd3);
        check_drained("signed");

        // Backpressure: four pixels fill the credits, then reads stop
        i_pat = 0; w_pat = 0; fill_imap();
        cur_mode = 1'b0; cur_size = 10; rdy_mode = 0;
        load_ch(0);
        r0 = ren_cnt;
        start(1);
        repeat (150) @(posedge clk);
        #1;
        check("bp_reads_held", 64'(ren_cnt - r0), 64'd36);
        check("bp_ren_low", bus.imap_ren, 1'b0);
        check("bp_out_vld", bus.out_vld, 1'b1);
        check("bp_state_run", dbg_state, 3'd2);
        rdy_mode = 1;
        wait_done(1000);
        check_drained("bp");

        // Ping-pong: only bank 0 ready, och 1 must wait
        do_reset("pp_reset");
        fill_imap();
        cur_mode = 1'b0; cur_size = 2;
        load_ch(0);
        start(3);
        c = 0;
        while (out_ch_cnt != 8'd1 && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (20) @(posedge clk);
        #1;
        check("pp_och_cnt", out_ch_cnt, 8'd1);
        check("pp_wait_state", dbg_state, 3'd1);
        check("pp_wait_ren", bus.imap_ren, 1'b0);
        load_ch(1);
        load_ch(2);
        wait_done(1000);
        check_drained("pp");

        // Write protection and ignored start
        do_reset("prot_reset");
        fill_imap();
        cur_mode = 1'b1; cur_size = 2;
        load_ch(0);
        wr_w(1'b0, 4'd0, {LANES{8'h7f}});
        wr_w(1'b0, 4'd3, {LANES{8'h7f}});
        r0 = ren_cnt;
        start(1);
        conv_mode = 1'b0; map_size = 16'd5; out_ch = 8'd4; conv_start = 1'b1;
        @(posedge clk); #1;
        conv_start = 1'b0;
        wait_done(300);
        check("prot_reads", 64'(ren_cnt - r0), 64'd2);
        check_drained("prot");

        // Empty jobs complete straight away
        r0 = ren_cnt;
        start(0);
        check("och0_done_c1", conv_done, 1'b1);
        check("och0_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("och0_done_pulse", conv_done, 1'b0);
        cur_size = 0;
        start(1);
        check("size0_done_c1", conv_done, 1'b1);
        @(posedge clk); #1;
        check("empty_no_reads", 64'(ren_cnt - r0), 64'd0);

        // Reset in RUN with two results buffered, then a clean rerun
        i_pat = 1; w_pat = 1; fill_imap();
        cur_mode = 1'b0; cur_size = 8; rdy_mode = 0;
        load_ch(0);
        r0 = ren_cnt;
        start(1);
        c = 0;
        while ((ren_cnt - r0) < 22 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("midrun_state", dbg_state, 3'd2);
        check("midrun_out_vld", bus.out_vld, 1'b1);
        do_reset("midrun");
        rdy_mode = 1; cur_size = 2;
        load_ch(0);
        r0 = ren_cnt;
        start(1);
        wait_done(500);
        check("rerun_reads", 64'(ren_cnt - r0), 64'd18);
        check_drained("rerun");

        // Randomized jobs with random backpressure
        i_pat = 0; w_pat = 0;
        for (int n = 0; n < 6; n++) begin
            int nch;
            fill_imap();
            cur_mode = 1'($urandom_range(0, 1));
            cur_size = $urandom_range(1, 12);
            nch = $urandom_range(1, 3);
            rdy_mode = 2;
            start(nch);
            fork
                auto_load(nch);
                wait_done(4000);
            join
            check_drained("rand");
        end
        rdy_mode = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
